// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath.
//   MODE_ADD / MODE_SUB : encodings of the add/subtract mode input.
//   calc_stages()       : number of pipeline stages for a width/segment split.
//   seg_cfg_ok()        : legality of a width/segment split (checked at
//                         elaboration by every user of the split).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int seg_width);
    return (seg_width > 0) ? (width / seg_width) : 1;
  endfunction

  function automatic bit seg_cfg_ok(input int width, input int seg_width);
    return (seg_width >= 1) && (width >= seg_width) && ((width % seg_width) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// ---------------------------------------------------------------------------
// adder_segment
// SEG_WIDTH-bit combinational ripple-carry adder.
// Ports:
//   a, b   in  SEG_WIDTH  operand slices (b already inverted for subtract)
//   ci     in  1          carry into bit 0
//   s      out SEG_WIDTH  sum slice
//   co     out 1          carry out of the top bit
//   c_msb  out 1          carry into the top bit (for overflow detection)
// ---------------------------------------------------------------------------
module adder_segment #(
  parameter int SEG_WIDTH = 4
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 ci,
  output logic [SEG_WIDTH-1:0] s,
  output logic                 co,
  output logic                 c_msb
);

  logic carry;

  always_comb begin
    carry = ci;
    c_msb = 1'b0;
    s     = '0;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      if (i == SEG_WIDTH - 1) begin
        c_msb = carry;
      end
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_adder_sub.sv
// ---------------------------------------------------------------------------
// pipelined_adder_sub
// WIDTH-bit add/subtract with the carry chain cut into SEG_WIDTH-bit segments,
// one register stage per segment, valid/ready handshake and result flags.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b         operands
//   in_c               carry-in (add) / borrow-in (sub)
//   in_mode            0 = add, 1 = subtract
//   out_valid/out_ready output handshake
//   sum_out            result modulo 2^WIDTH
//   c_out              carry out of MSB (sub: 1 = no borrow)
//   v_out              two's-complement overflow
//   z_out              sum_out == 0
// ---------------------------------------------------------------------------
module pipelined_adder_sub
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             v_out,
  output logic             z_out
);

  localparam int STAGES = calc_stages(WIDTH, SEG_WIDTH);
  localparam int LAST   = STAGES - 1;

  if (!seg_cfg_ok(WIDTH, SEG_WIDTH)) begin : g_bad_cfg
    $error("pipelined_adder_sub: WIDTH must be a positive multiple of SEG_WIDTH");
  end

  // Whole pipe moves together; a stalled output freezes every stage, bubbles included.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Source of each stage: stage 0 reads the ports, stage k reads register k-1.
  logic                 src_vld [STAGES];
  logic [WIDTH-1:0]     src_a   [STAGES];
  logic [WIDTH-1:0]     src_b   [STAGES];
  logic [WIDTH-1:0]     src_sum [STAGES];
  logic                 src_cy  [STAGES];

  logic [SEG_WIDTH-1:0] seg_s   [STAGES];
  logic                 seg_co  [STAGES];
  logic                 seg_cm  [STAGES];

  logic                 vld_d   [STAGES];
  logic [WIDTH-1:0]     a_d     [STAGES];
  logic [WIDTH-1:0]     b_d     [STAGES];
  logic [WIDTH-1:0]     sum_d   [STAGES];
  logic                 cy_d    [STAGES];
  logic                 cm_d    [STAGES];
  logic                 z_d;

  logic                 vld_q   [STAGES];
  logic [WIDTH-1:0]     a_q     [STAGES];
  logic [WIDTH-1:0]     b_q     [STAGES];
  logic [WIDTH-1:0]     sum_q   [STAGES];
  logic                 cy_q    [STAGES];
  logic                 cm_q    [STAGES];
  logic                 z_q;

  // Subtract is A + ~B + ~borrow, so both B and the carry-in are inverted up front.
  always_comb begin
    src_vld[0] = in_valid;
    src_a[0]   = in_a;
    src_b[0]   = (in_mode == MODE_SUB) ? ~in_b : in_b;
    src_cy[0]  = (in_mode == MODE_SUB) ? ~in_c : in_c;
    src_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_cy[k]  = cy_q[k-1];
      src_sum[k] = sum_q[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_seg
    adder_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .a     (src_a[g][g*SEG_WIDTH +: SEG_WIDTH]),
      .b     (src_b[g][g*SEG_WIDTH +: SEG_WIDTH]),
      .ci    (src_cy[g]),
      .s     (seg_s[g]),
      .co    (seg_co[g]),
      .c_msb (seg_cm[g])
    );
  end

  // Stage k fills in its own result segment and passes everything else along.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = src_vld[k];
      a_d[k]   = src_a[k];
      b_d[k]   = src_b[k];
      sum_d[k] = src_sum[k];
      sum_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg_s[k];
      cy_d[k]  = seg_co[k];
      cm_d[k]  = seg_cm[k];
    end
    z_d = (sum_d[LAST] == '0);
  end

  // Stage registers: data only loads when a real operation enters the slot,
  // so the output stays put across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
        cm_q[k]  <= 1'b0;
      end
      z_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        if (vld_d[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sum_q[k] <= sum_d[k];
          cy_q[k]  <= cy_d[k];
          cm_q[k]  <= cm_d[k];
        end
      end
      if (vld_d[LAST]) begin
        z_q <= z_d;
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign sum_out   = sum_q[LAST];
  assign c_out     = cy_q[LAST];
  assign v_out     = cy_q[LAST] ^ cm_q[LAST];
  assign z_out     = z_q;

endmodule
